// File: rtl/mmio_pwm_timer_if.sv
// Load/store port between the core (master) and the PWM/timer peripheral (slave).
interface mmio_pwm_timer_if;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        hit;

    modport master (
        output write_mem, funct3, write_address, write_data, read_address,
        input  read_data, hit
    );

    modport slave (
        input  write_mem, funct3, write_address, write_data, read_address,
        output read_data, hit
    );
endinterface

// File: rtl/mmio_pwm_timer.sv
// mmio_pwm_timer: memory-mapped peripheral with four 8-bit PWM channels
// (led/red/green/blue) and a 32-bit tick timer with sticky compare flag and irq.
module mmio_pwm_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned TICK_DIV  = 12
) (
    input  logic            clk,
    input  logic            reset,
    mmio_pwm_timer_if.slave bus,
    output logic            led,
    output logic            red,
    output logic            green,
    output logic            blue,
    output logic            irq
);
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 32'd1);

    // Byte enables for a store: byte lane from addr[1:0], half lane from addr[1].
    function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            3'b000, 3'b100: be = 4'b0001 << a;
            3'b001, 3'b101: be = a[1] ? 4'b1100 : 4'b0011;
            3'b010:         be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data onto every lane it could target.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000, 3'b100: d = {4{wd[7:0]}};
            3'b001, 3'b101: d = {2{wd[15:0]}};
            default:        d = wd;
        endcase
        return d;
    endfunction

    // Replace only the enabled byte lanes of a register.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] nd,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? nd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    logic [31:0] duty_q, duty_d, count_q, count_d, cmp_q, cmp_d;
    logic [15:0] presc_q, presc_d, pc_q, pc_d, div_q, div_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [3:0]  pwm_q, pwm_d;
    logic        match_q, match_d, irq_en_q, irq_en_d, hit_q, hit_d;
    logic [31:0] read_data_q, read_data_d;

    logic [3:0]  be_s;
    logic [31:0] wdata_s, count_inc_s, rd_word_s, rd_shift_s;
    logic        duty_wr_s, presc_wr_s, count_wr_s, cmp_wr_s, status_wr_s;
    logic        div_wrap_s, match_set_s, match_clr_s, tick_s;

    // Store decode: window match, lane enables and per-register write strobes.
    always_comb begin
        if (bus.write_mem && (bus.write_address[31:5] == BASE_ADDR[31:5])) begin
            be_s = lane_enables(bus.funct3, bus.write_address[1:0]);
        end else begin
            be_s = 4'b0000;
        end
        wdata_s     = lane_data(bus.funct3, bus.write_data);
        duty_wr_s   = (be_s != 4'b0000) && (bus.write_address[4:2] == 3'd0);
        presc_wr_s  = (be_s != 4'b0000) && (bus.write_address[4:2] == 3'd1);
        count_wr_s  = (be_s != 4'b0000) && (bus.write_address[4:2] == 3'd2);
        cmp_wr_s    = (be_s != 4'b0000) && (bus.write_address[4:2] == 3'd3);
        status_wr_s = (be_s != 4'b0000) && (bus.write_address[4:2] == 3'd4);
    end

    // Register file and timer: a software COUNT write beats the increment, match set beats W1C.
    always_comb begin
        duty_d  = duty_wr_s ? merge_lanes(duty_q, wdata_s, be_s) : duty_q;
        cmp_d   = cmp_wr_s ? merge_lanes(cmp_q, wdata_s, be_s) : cmp_q;
        if (presc_wr_s) begin
            presc_d = {be_s[1] ? wdata_s[15:8] : presc_q[15:8],
                       be_s[0] ? wdata_s[7:0]  : presc_q[7:0]};
        end else begin
            presc_d = presc_q;
        end
        div_wrap_s  = (div_q == DIV_LAST);
        div_d       = div_wrap_s ? 16'h0000 : div_q + 16'h0001;
        count_inc_s = count_q + 32'h0000_0001;
        if (count_wr_s) begin
            count_d = merge_lanes(count_q, wdata_s, be_s);
        end else if (div_wrap_s) begin
            count_d = count_inc_s;
        end else begin
            count_d = count_q;
        end
        match_set_s = div_wrap_s && !count_wr_s && (count_inc_s == cmp_q);
        match_clr_s = status_wr_s && be_s[0] && wdata_s[0];
        if (match_set_s) begin
            match_d = 1'b1;
        end else if (match_clr_s) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end
        irq_en_d = (status_wr_s && be_s[1]) ? wdata_s[8] : irq_en_q;
    end

    // PWM: prescaler produces ticks, 8-bit counter compared against each duty byte.
    always_comb begin
        tick_s    = (pc_q == presc_q);
        pc_d      = (presc_wr_s || tick_s) ? 16'h0000 : pc_q + 16'h0001;
        pwm_cnt_d = tick_s ? pwm_cnt_q + 8'h01 : pwm_cnt_q;
        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (pwm_cnt_q < duty_q[8*i +: 8]);
        end
    end

    // Load path: select the addressed register (pre-write value) and right-align it.
    always_comb begin
        case (bus.read_address[4:2])
            3'd0:    rd_word_s = duty_q;
            3'd1:    rd_word_s = {16'h0000, presc_q};
            3'd2:    rd_word_s = count_q;
            3'd3:    rd_word_s = cmp_q;
            3'd4:    rd_word_s = {23'h000000, irq_en_q, 7'h00, match_q};
            default: rd_word_s = 32'h0000_0000;
        endcase
        case (bus.funct3)
            3'b000, 3'b100: rd_shift_s = rd_word_s >> {bus.read_address[1:0], 3'b000};
            3'b001, 3'b101: rd_shift_s = rd_word_s >> {bus.read_address[1], 4'b0000};
            default:        rd_shift_s = rd_word_s;
        endcase
        hit_d       = (bus.read_address[31:5] == BASE_ADDR[31:5]);
        read_data_d = hit_d ? rd_shift_s : 32'h0000_0000;
    end

    // State registers with synchronous reset; a store in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q      <= 32'h0000_0000;
            presc_q     <= 16'h0000;
            count_q     <= 32'h0000_0000;
            cmp_q       <= 32'hFFFF_FFFF;
            match_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            pc_q        <= 16'h0000;
            div_q       <= 16'h0000;
            pwm_cnt_q   <= 8'h00;
            pwm_q       <= 4'b0000;
            read_data_q <= 32'h0000_0000;
            hit_q       <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            cmp_q       <= cmp_d;
            match_q     <= match_d;
            irq_en_q    <= irq_en_d;
            pc_q        <= pc_d;
            div_q       <= div_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_q       <= pwm_d;
            read_data_q <= read_data_d;
            hit_q       <= hit_d;
        end
    end

    assign led           = pwm_q[0];
    assign red           = pwm_q[1];
    assign green         = pwm_q[2];
    assign blue          = pwm_q[3];
    assign irq           = match_q & irq_en_q;
    assign bus.read_data = read_data_q;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Scoreboard bench for mmio_pwm_timer: randomized and directed loads/stores
// checked against an arithmetic reference model of the register map.
module tb_mmio_pwm_timer;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int unsigned TD   = 2;

    logic clk = 1'b0;
    logic reset;
    logic led, red, green, blue, irq;

    mmio_pwm_timer_if bus ();

    mmio_pwm_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .led(led), .red(red), .green(green), .blue(blue), .irq(irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_duty, m_cnt_val, m_cmp;
    logic [15:0] m_presc;
    logic        m_match, m_arm, m_irq_en;
    int unsigned m_cnt_edge, r_edge;

    // COUNT after edge e: written value plus the number of divider periods completed since.
    function automatic logic [31:0] m_count(input int unsigned e);
        return m_cnt_val + ((e - r_edge) / TD) - ((m_cnt_edge - r_edge) / TD);
    endfunction

    function automatic logic match_at(input int unsigned e);
        return m_match || (m_arm && (m_count(e) >= m_cmp));
    endfunction

    function automatic logic [31:0] m_word(input logic [2:0] off, input int unsigned e);
        case (off)
            3'd0:    return m_duty;
            3'd1:    return {16'h0000, m_presc};
            3'd2:    return m_count(e);
            3'd3:    return m_cmp;
            3'd4:    return {23'h0, m_irq_en, 7'h0, match_at(e)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rd_shift(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: return w >> (32'd8 * 32'(a));
            3'b001, 3'b101: return w >> (32'd16 * 32'(a[1]));
            default:        return w;
        endcase
    endfunction

    task automatic model_reset();
        m_duty = 32'h0; m_presc = 16'h0; m_cnt_val = 32'h0; m_cnt_edge = r_edge;
        m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_arm = 1'b0; m_irq_en = 1'b0;
    endtask

    // Apply a store that lands on edge e.
    task automatic model_write(input logic [2:0] f3, input logic [31:0] wa, input logic [31:0] wd,
                               input int unsigned e);
        logic [31:0] mask, val, cur;
        logic set_e;
        if (wa[31:5] != BASE[31:5]) return;
        case (f3)
            3'b000, 3'b100: begin
                mask = 32'h0000_00FF << (32'd8 * 32'(wa[1:0]));
                val  = (wd & 32'h0000_00FF) << (32'd8 * 32'(wa[1:0]));
            end
            3'b001, 3'b101: begin
                mask = 32'h0000_FFFF << (32'd16 * 32'(wa[1]));
                val  = (wd & 32'h0000_FFFF) << (32'd16 * 32'(wa[1]));
            end
            3'b010:  begin mask = 32'hFFFF_FFFF; val = wd; end
            default: return;
        endcase
        case (wa[4:2])
            3'd0: m_duty = (m_duty & ~mask) | val;
            3'd1: m_presc = 16'(({16'h0, m_presc} & ~mask) | val);
            3'd2: begin
                cur = m_count(e - 1);
                m_cnt_val = (cur & ~mask) | val;
                m_cnt_edge = e;
            end
            3'd3: m_cmp = (m_cmp & ~mask) | val;
            3'd4: begin
                if (mask[0] && val[0]) begin
                    set_e = m_arm && (m_count(e) >= m_cmp) && (m_count(e - 1) < m_cmp);
                    if (set_e) begin
                        m_match = 1'b1; m_arm = 1'b0;
                    end else begin
                        m_match = 1'b0;
                        if (m_arm && (m_count(e) >= m_cmp)) m_arm = 1'b0;
                    end
                end
                if (mask[8]) m_irq_en = val[8];
            end
            default: ;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: compare read_data/hit against the expectation due on this edge.
    always @(posedge clk) begin
        #2;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check($sformatf("hit rd@%h", mon_e.addr), {31'h0, bus.hit}, {31'h0, mon_e.hit});
            check($sformatf("data rd@%h", mon_e.addr), bus.read_data, mon_e.data);
        end
    end

    // One bus cycle driven at the negedge; sampled by the DUT on the following edge.
    task automatic bus_cycle(input logic wr, input logic [2:0] f3, input logic [31:0] wa,
                             input logic [31:0] wd, input logic rd, input logic [31:0] ra);
        exp_t x;
        int unsigned e;
        @(negedge clk);
        e = cyc + 1;
        if (rd) begin
            x.due  = e;
            x.addr = ra;
            x.hit  = (ra[31:5] == BASE[31:5]);
            x.data = x.hit ? rd_shift(m_word(ra[4:2], cyc), f3, ra[1:0]) : 32'h0;
            exp_q.push_back(x);
        end
        bus.write_mem     = wr;
        bus.funct3        = f3;
        bus.write_address = wa;
        bus.write_data    = wd;
        bus.read_address  = rd ? ra : 32'h0;
        if (wr) model_write(f3, wa, wd, e);
    endtask

    task automatic idle();
        bus_cycle(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask
    task automatic wr(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus_cycle(1'b1, f3, a, d, 1'b0, 32'h0);
    endtask
    task automatic rd(input logic [2:0] f3, input logic [31:0] a);
        bus_cycle(1'b0, f3, 32'h0, 32'h0, 1'b1, a);
    endtask

    task automatic check_irq(input string nm);
        @(posedge clk); #1;
        check(nm, {31'h0, irq}, {31'h0, match_at(cyc) & m_irq_en});
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, " led"}, {31'h0, led}, 32'h0);
        check({nm, " red"}, {31'h0, red}, 32'h0);
        check({nm, " green"}, {31'h0, green}, 32'h0);
        check({nm, " blue"}, {31'h0, blue}, 32'h0);
        check({nm, " irq"}, {31'h0, irq}, 32'h0);
        check({nm, " hit"}, {31'h0, bus.hit}, 32'h0);
        check({nm, " rdata"}, bus.read_data, 32'h0);
    endtask

    // Count high cycles per channel over n cycles (a whole number of PWM periods).
    task automatic measure_pwm(input int n);
        int cnt [4];
        int per;
        int ex;
        logic [31:0] dm;
        repeat (3) idle();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            cnt[0] += int'(led); cnt[1] += int'(red); cnt[2] += int'(green); cnt[3] += int'(blue);
        end
        per = n / (256 * (int'(m_presc) + 1));
        dm = m_duty;
        for (int i = 0; i < 4; i++) begin
            ex = int'(dm[8*i +: 8]) * (int'(m_presc) + 1) * per;
            check($sformatf("pwm ch%0d high count", i), 32'(cnt[i]), 32'(ex));
        end
    endtask

    task automatic read_all_word();
        for (int o = 0; o < 6; o++) rd(3'b010, BASE + 32'(4 * o));
    endtask

    initial begin
        int unsigned b;
        logic [31:0] a, d;
        logic [2:0] offs [6];
        offs[0] = 3'd0; offs[1] = 3'd1; offs[2] = 3'd4; offs[3] = 3'd5; offs[4] = 3'd6; offs[5] = 3'd7;

        reset = 1'b1;
        bus.write_mem = 1'b0; bus.funct3 = 3'b010; bus.write_address = 32'h0;
        bus.write_data = 32'h0; bus.read_address = 32'h0;
        repeat (3) @(negedge clk);
        r_edge = cyc;
        model_reset();
        check_outputs_zero("reset");
        reset = 1'b0;

        // 1: reset values of every offset
        read_all_word();

        // 2: byte store and lbu, then red duty 128/256
        wr(3'b000, BASE + 32'h1, {$urandom_range(0, 32'h00FF_FFFF), 8'h80} );
        rd(3'b100, BASE + 32'h1);
        rd(3'b010, BASE);
        rd(3'b001, BASE + 32'h3);
        measure_pwm(256);

        // 3: PRESC=3, DUTY=FF000001, out-of-window read
        wr(3'b010, BASE + 32'h4, {16'($urandom), 16'h0003});
        wr(3'b010, BASE, 32'hFF00_0001);
        rd(3'b010, BASE + 32'h4);
        rd(3'b010, BASE + 32'h20);
        measure_pwm(1024);

        // random register traffic (DUTY/PRESC/STATUS/unmapped/out-of-window) with random reads
        for (int k = 0; k < 80; k++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom & 32'h7FFF_FFFF;
            else a = BASE + {27'h0, offs[$urandom_range(0, 5)], 2'(d[31:30])};
            bus_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, d,
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0) ? $urandom : BASE + 32'($urandom_range(0, 31)));
        end
        check_irq("irq random phase");
        for (int k = 0; k < 2; k++) begin
            wr(3'b010, BASE + 32'h4, 32'($urandom_range(0, 1)));
            wr(3'b010, BASE, $urandom);
            measure_pwm(512);
        end

        // 4: compare match, irq gating, W1C, set-wins-over-clear
        wr(3'b010, BASE + 32'h10, 32'h0);
        wr(3'b010, BASE + 32'hC, 32'd5);
        wr(3'b010, BASE + 32'h8, 32'd0);
        m_arm = 1'b1;
        for (int k = 0; k < 14; k++) rd(3'b010, BASE + 32'h10);
        check_irq("irq masked");
        wr(3'b010, BASE + 32'h10, 32'h100);
        check_irq("irq enabled");
        wr(3'b010, BASE + 32'h10, 32'h101);
        check_irq("irq after w1c");
        rd(3'b010, BASE + 32'h10);
        wr(3'b010, BASE + 32'h8, 32'd0);
        m_arm = 1'b1;
        b = cyc + 2;
        while (m_count(b) != 32'd5) b++;
        while (cyc + 2 < b) idle();
        wr(3'b010, BASE + 32'h10, 32'h101);
        check_irq("irq set wins");
        rd(3'b010, BASE + 32'h10);

        // 5: COUNT wrap with no match, COUNT write on a tick edge
        wr(3'b010, BASE + 32'h10, 32'h001);
        wr(3'b010, BASE + 32'h8, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) rd(3'b010, BASE + 32'h8);
        rd(3'b010, BASE + 32'h10);
        b = cyc + 3;
        while (((b - r_edge) % TD) != 0) b++;
        while (cyc + 2 < b) idle();
        wr(3'b010, BASE + 32'h8, 32'd100);
        for (int k = 0; k < 3; k++) rd(3'b010, BASE + 32'h8);

        // 6: reset during PWM activity with a pending store and read
        wr(3'b010, BASE, 32'hFFFF_FFFF);
        wr(3'b010, BASE + 32'h10, 32'h100);
        repeat (5) idle();
        @(negedge clk);
        reset = 1'b1;
        bus.write_mem = 1'b1; bus.funct3 = 3'b010; bus.write_address = BASE + 32'hC;
        bus.write_data = 32'h1234_5678; bus.read_address = BASE;
        @(negedge clk);
        r_edge = cyc;
        model_reset();
        check_outputs_zero("mid reset");
        reset = 1'b0;
        bus.write_mem = 1'b0; bus.read_address = 32'h0;
        read_all_word();
        check_irq("irq after reset");

        repeat (4) idle();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d reads left unanswered, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
